// File: rtl/bist_pkg.sv
// Shared types and width defaults for the BIST signature checker.
// Pure declarations: no logic, no latency.
package bist_pkg;

    localparam int SISR_SIZE_DEF = 16;
    localparam int CNT_W_DEF     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMP   = 2'd1,
        SHIFT = 2'd2
    } chk_state_t;

endpackage

// File: rtl/bist_sig_checker_if.sv
// Golden-table load, capture, result and serial-unload signals of the checker.
// master = tester/monitor side, slave = checker side.
interface bist_sig_checker_if
    import bist_pkg::*;
#(
    parameter int SISR_Size = SISR_SIZE_DEF,
    parameter int CFG_W     = 2,
    parameter int CNT_W     = CNT_W_DEF
) ();

    logic                 gold_we;
    logic [CFG_W-1:0]     gold_addr;
    logic [SISR_Size-1:0] gold_data;
    logic [CFG_W-1:0]     cfg_sel;
    logic                 done;
    logic [SISR_Size-1:0] sig_in;
    logic                 unload_en;
    logic                 sout;
    logic                 sout_valid;
    logic                 sout_ready;
    logic                 sout_last;
    logic                 pass;
    logic                 fail;
    logic [CNT_W-1:0]     run_cnt;
    logic [CNT_W-1:0]     fail_cnt;
    logic                 overrun;

    modport master (
        output gold_we, gold_addr, gold_data, cfg_sel, done, sig_in, unload_en, sout_ready,
        input  sout, sout_valid, sout_last, pass, fail, run_cnt, fail_cnt, overrun
    );

    modport slave (
        input  gold_we, gold_addr, gold_data, cfg_sel, done, sig_in, unload_en, sout_ready,
        output sout, sout_valid, sout_last, pass, fail, run_cnt, fail_cnt, overrun
    );

endinterface

// File: rtl/sig_unload_shifter.sv
// Captured-signature register with MSB-first valid/ready serial unload.
// Load takes one edge; one bit leaves per accepted handshake; i_rdy low stalls with sout held.
module sig_unload_shifter
    import bist_pkg::*;
#(
    parameter int W = SISR_SIZE_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_dat,
    input  logic         i_active,
    input  logic         i_rdy,
    output logic [W-1:0] o_sig,
    output logic         o_sout,
    output logic         o_vld,
    output logic         o_last,
    output logic         o_end
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  r_sig;
    logic [CW-1:0] r_cnt;
    logic          w_hs;
    logic          w_at_last;

    assign w_hs      = i_active & i_rdy;
    assign w_at_last = (r_cnt == CW'(W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sig <= i_load_dat;
            r_cnt <= '0;
        end else if (w_hs) begin
            r_sig <= r_sig << 1;
            r_cnt <= w_at_last ? '0 : r_cnt + CW'(1);
        end
    end

    // Outputs are quiet outside an unload so a stray sout never reaches the tester.
    assign o_sig  = r_sig;
    assign o_sout = i_active & r_sig[W-1];
    assign o_vld  = i_active;
    assign o_last = i_active & w_at_last;
    assign o_end  = w_hs & w_at_last;

endmodule

// File: rtl/bist_sig_checker.sv
// Captures the SISR signature on a done rise, compares it with the golden entry for cfg_sel.
// pass/fail pulse 2 edges after the rise; optional serial unload throttled by sout_ready.
module bist_sig_checker
    import bist_pkg::*;
#(
    parameter int SISR_Size = SISR_SIZE_DEF,
    parameter int NUM_CFG   = 4,
    parameter int CFG_W     = 2,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    bist_sig_checker_if.slave bus
);

    chk_state_t           r_state;
    chk_state_t           w_state_nxt;
    logic                 r_done_q;
    logic                 w_rise;
    logic                 w_capture;
    logic                 w_in_cmp;
    logic                 w_in_shift;
    logic                 w_unload_end;

    logic [SISR_Size-1:0] r_gold [NUM_CFG];
    logic [NUM_CFG-1:0]   r_gold_vld;
    logic [SISR_Size-1:0] w_rd_dat;
    logic                 w_rd_vld;
    logic [SISR_Size-1:0] r_gold_q;
    logic                 r_vld_q;
    logic [SISR_Size-1:0] w_sig_q;
    logic                 w_match;

    logic                 r_pass;
    logic                 r_fail;
    logic [CNT_W-1:0]     r_run_cnt;
    logic [CNT_W-1:0]     r_fail_cnt;
    logic                 r_overrun;

    assign w_rise = bus.done & ~r_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_q <= 1'b0;
        end else begin
            r_done_q <= bus.done;
        end
    end

    // Table data has no reset; validity bits alone decide whether an entry counts.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CFG; i++) begin
            if (bus.gold_we && (bus.gold_addr == CFG_W'(i))) begin
                r_gold[i] <= bus.gold_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gold_vld <= '0;
        end else begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (bus.gold_we && (bus.gold_addr == CFG_W'(i))) begin
                    r_gold_vld[i] <= 1'b1;
                end
            end
        end
    end

    // Out-of-range cfg_sel matches no entry and reads as invalid.
    always_comb begin
        w_rd_dat = '0;
        w_rd_vld = 1'b0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (bus.cfg_sel == CFG_W'(i)) begin
                w_rd_dat = r_gold[i];
                w_rd_vld = r_gold_vld[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_in_cmp    = 1'b0;
        w_in_shift  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_capture   = 1'b1;
                    w_state_nxt = CMP;
                end
            end
            CMP: begin
                w_in_cmp    = 1'b1;
                w_state_nxt = bus.unload_en ? SHIFT : IDLE;
            end
            SHIFT: begin
                w_in_shift = 1'b1;
                if (w_unload_end) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gold_q <= '0;
            r_vld_q  <= 1'b0;
        end else if (w_capture) begin
            r_gold_q <= w_rd_dat;
            r_vld_q  <= w_rd_vld;
        end
    end

    sig_unload_shifter #(
        .W (SISR_Size)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_capture),
        .i_load_dat (bus.sig_in),
        .i_active   (w_in_shift),
        .i_rdy      (bus.sout_ready),
        .o_sig      (w_sig_q),
        .o_sout     (bus.sout),
        .o_vld      (bus.sout_valid),
        .o_last     (bus.sout_last),
        .o_end      (w_unload_end)
    );

    assign w_match = r_vld_q & (w_sig_q == r_gold_q);

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_run_cnt  <= '0;
            r_fail_cnt <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_pass <= w_in_cmp & w_match;
            r_fail <= w_in_cmp & ~w_match;
            if (w_in_cmp) begin
                if (r_run_cnt != '1) begin
                    r_run_cnt <= r_run_cnt + CNT_W'(1);
                end
                if (!w_match && (r_fail_cnt != '1)) begin
                    r_fail_cnt <= r_fail_cnt + CNT_W'(1);
                end
            end
            if (w_rise && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.pass     = r_pass;
    assign bus.fail     = r_fail;
    assign bus.run_cnt  = r_run_cnt;
    assign bus.fail_cnt = r_fail_cnt;
    assign bus.overrun  = r_overrun;

endmodule

// File: tb/tb_bist_sig_checker.sv
// Directed plus randomized checks of bist_sig_checker against a transaction-level model.
// Two instances share stimulus: 8-bit counters and 2-bit counters for saturation.
module tb_bist_sig_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gold_we = 1'b0;
    logic [1:0]  gold_addr = '0;
    logic [15:0] gold_data = '0;
    logic [1:0]  cfg_sel = '0;
    logic        done = 1'b0;
    logic [15:0] sig_in = '0;
    logic        unload_en = 1'b0;
    logic        sout_ready = 1'b0;

    always #5 clk = ~clk;

    bist_sig_checker_if #(.SISR_Size(16), .CFG_W(2), .CNT_W(8)) bus8 ();
    bist_sig_checker_if #(.SISR_Size(16), .CFG_W(2), .CNT_W(2)) bus2 ();

    assign bus8.gold_we    = gold_we;
    assign bus8.gold_addr  = gold_addr;
    assign bus8.gold_data  = gold_data;
    assign bus8.cfg_sel    = cfg_sel;
    assign bus8.done       = done;
    assign bus8.sig_in     = sig_in;
    assign bus8.unload_en  = unload_en;
    assign bus8.sout_ready = sout_ready;
    assign bus2.gold_we    = gold_we;
    assign bus2.gold_addr  = gold_addr;
    assign bus2.gold_data  = gold_data;
    assign bus2.cfg_sel    = cfg_sel;
    assign bus2.done       = done;
    assign bus2.sig_in     = sig_in;
    assign bus2.unload_en  = unload_en;
    assign bus2.sout_ready = sout_ready;

    bist_sig_checker #(.SISR_Size(16), .NUM_CFG(4), .CFG_W(2), .CNT_W(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    bist_sig_checker #(.SISR_Size(16), .NUM_CFG(4), .CFG_W(2), .CNT_W(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    int          tests = 0;
    int          fails = 0;
    logic [15:0] m_gold [4];
    bit          m_vld  [4];
    int          m_run  = 0;
    int          m_fail = 0;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_run8"},  32'(bus8.run_cnt),  32'(sat(m_run, 255)));
        chk({tag, "_fail8"}, 32'(bus8.fail_cnt), 32'(sat(m_fail, 255)));
        chk({tag, "_run2"},  32'(bus2.run_cnt),  32'(sat(m_run, 3)));
        chk({tag, "_fail2"}, 32'(bus2.fail_cnt), 32'(sat(m_fail, 3)));
    endtask

    task automatic wr_gold(input logic [1:0] a, input logic [15:0] d);
        gold_we = 1'b1; gold_addr = a; gold_data = d;
        step();
        gold_we = 1'b0;
        m_gold[a] = d;
        m_vld[a]  = 1'b1;
    endtask

    // mode 0: ready toggles 1/0; mode 1: random ready. ovr_at >= 0 pulses done on that cycle.
    task automatic unload(input logic [15:0] exp_sig, input int mode, input int ovr_at);
        logic [15:0] got;
        int          nb;
        int          cyc;
        bit          rdy;
        bit          last_ok;
        got = '0; nb = 0; cyc = 0; last_ok = 1'b1;
        while (nb < 16 && cyc < 200) begin
            rdy        = (mode == 0) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            sout_ready = rdy;
            done       = (cyc == ovr_at);
            if (bus8.sout_last !== ((nb == 15) && bus8.sout_valid)) last_ok = 1'b0;
            if (rdy && bus8.sout_valid) begin
                got = {got[14:0], bus8.sout};
                nb++;
            end
            step();
            cyc++;
        end
        sout_ready = 1'b0;
        done       = 1'b0;
        chk("unload_nbits", 32'(nb), 32'd16);
        chk("unload_bits", 32'(got), 32'(exp_sig));
        chk("unload_last_only16", 32'(last_ok), 32'd1);
        chk("unload_back_idle", 32'(bus8.sout_valid), 32'd0);
    endtask

    task automatic do_compare(input logic [1:0] cfg, input logic [15:0] sig, input bit unl,
                              input int mode, input int ovr_at);
        bit ep;
        ep = m_vld[cfg] && (m_gold[cfg] == sig);
        cfg_sel = cfg; sig_in = sig; unload_en = unl; done = 1'b1;
        step();
        done = 1'b0;
        chk("cmp_no_early_pulse", 32'({bus8.pass, bus8.fail}), 32'd0);
        step();
        unload_en = 1'b0;
        m_run++;
        if (!ep) m_fail++;
        chk("pass", 32'(bus8.pass), 32'(ep));
        chk("fail", 32'(bus8.fail), 32'(!ep));
        check_counts("cmp");
        if (unl) begin
            unload(sig, mode, ovr_at);
        end else begin
            step();
            chk("pulse_one_cycle", 32'({bus8.pass, bus8.fail}), 32'd0);
        end
    endtask

    initial begin
        int          npulse;
        bit          ep;
        logic [1:0]  c;
        logic [15:0] s;
        for (int i = 0; i < 4; i++) begin
            m_gold[i] = '0;
            m_vld[i]  = 1'b0;
        end

        // Reset state
        step();
        step();
        rst = 1'b0;
        chk("rst_pass", 32'(bus8.pass), 32'd0);
        chk("rst_fail", 32'(bus8.fail), 32'd0);
        chk("rst_run", 32'(bus8.run_cnt), 32'd0);
        chk("rst_failcnt", 32'(bus8.fail_cnt), 32'd0);
        chk("rst_overrun", 32'(bus8.overrun), 32'd0);
        chk("rst_sout_valid", 32'(bus8.sout_valid), 32'd0);
        chk("rst_sout_last", 32'(bus8.sout_last), 32'd0);
        chk("rst_sout", 32'(bus8.sout), 32'd0);

        // Golden hit then miss
        wr_gold(2'd1, 16'hA5C3);
        do_compare(2'd1, 16'hA5C3, 1'b0, 0, -1);
        do_compare(2'd1, 16'hA5C2, 1'b0, 0, -1);

        // Write and capture of the same index in one cycle: old entry is compared
        wr_gold(2'd2, 16'h1234);
        ep = m_vld[2] && (m_gold[2] == 16'h1234);
        cfg_sel = 2'd2; sig_in = 16'h1234; unload_en = 1'b0; done = 1'b1;
        gold_we = 1'b1; gold_addr = 2'd2; gold_data = 16'hBEEF;
        step();
        done = 1'b0; gold_we = 1'b0;
        m_gold[2] = 16'hBEEF; m_vld[2] = 1'b1;
        step();
        m_run++;
        if (!ep) m_fail++;
        chk("wr_rd_old_pass", 32'(bus8.pass), 32'(ep));
        check_counts("wr_rd");
        step();
        do_compare(2'd2, 16'hBEEF, 1'b0, 0, -1);

        // Serial unload with ready toggling
        do_compare(2'd0, 16'h8001, 1'b1, 0, -1);
        chk("no_overrun_yet", 32'(bus8.overrun), 32'd0);

        // Done pulse during SHIFT: overrun set, unloaded signature undisturbed
        s = 16'($urandom());
        do_compare(2'd1, s, 1'b1, 1, 3);
        chk("overrun_set", 32'(bus8.overrun), 32'd1);
        check_counts("after_ovr");

        // Done held high for 50 cycles yields one capture
        ep = m_vld[1] && (m_gold[1] == 16'hA5C3);
        cfg_sel = 2'd1; sig_in = 16'hA5C3; unload_en = 1'b0; done = 1'b1;
        npulse = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bus8.pass || bus8.fail) npulse++;
        end
        done = 1'b0;
        step();
        m_run++;
        if (!ep) m_fail++;
        chk("hold_one_pulse", 32'(npulse), 32'd1);
        check_counts("hold");

        // Randomized compares, writes and unloads
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) wr_gold(2'($urandom_range(0, 3)), 16'($urandom()));
            c = 2'($urandom_range(0, 3));
            s = ($urandom_range(0, 1) == 1) ? m_gold[c] : 16'($urandom());
            do_compare(c, s, ($urandom_range(0, 3) == 0), 1, -1);
        end

        // Reset in the middle of an unload
        wr_gold(2'd3, 16'h0000);
        cfg_sel = 2'd1; sig_in = 16'($urandom()); unload_en = 1'b1; done = 1'b1;
        step();
        done = 1'b0;
        step();
        unload_en = 1'b0; sout_ready = 1'b1;
        step();
        step();
        chk("mid_shift_valid", 32'(bus8.sout_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0; sout_ready = 1'b0;
        m_run = 0; m_fail = 0;
        for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
        chk("rst_abort_valid", 32'(bus8.sout_valid), 32'd0);
        chk("rst_abort_overrun", 32'(bus8.overrun), 32'd0);
        check_counts("rst_abort");
        step();
        chk("rst_abort_no_pulse", 32'({bus8.pass, bus8.fail}), 32'd0);

        // Cleared valid bits: entries read as unwritten even where data matches
        do_compare(2'd3, 16'h0000, 1'b0, 0, -1);
        do_compare(2'd1, 16'hA5C3, 1'b0, 0, -1);
        for (int i = 0; i < 5; i++) do_compare(2'd2, 16'($urandom()), 1'b0, 0, -1);
        chk("sat_fail2", 32'(bus2.fail_cnt), 32'd3);
        chk("sat_run2", 32'(bus2.run_cnt), 32'd3);
        chk("nosat_fail8", 32'(bus8.fail_cnt), 32'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
